// File: rtl/pong_pkg.sv
// Shared pong definitions: match states and serve directions.
// Imported by the match sequencer and the ball datapath.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SERVE    = 2'd1,
        ST_PLAY     = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Bits needed to hold max(a, b) - 1, never less than one.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = ((a > b) ? a : b) - 1;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pong_match_ctrl_tick_timer.sv
// Tick-enabled delay counter shared by the serve countdown
// and the game-over timeout.
module pong_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] term,
    output logic         done
);

    logic [W-1:0] count;

    assign done = tick && (count == term);

    // Count ticks, wrap at terminal count, clear on state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game state, scores, serve direction
// and ball hold/launch control. All outputs are registered.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = 7,
    parameter int SCORE_BITS     = 4,
    parameter int SERVE_TICKS    = 180,
    parameter int GAMEOVER_TICKS = 600
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  point_left,
    input  logic                  point_right,
    output logic                  ball_hold,
    output logic                  ball_launch,
    output logic                  launch_dir,
    output logic [SCORE_BITS-1:0] score_left,
    output logic [SCORE_BITS-1:0] score_right,
    output logic                  game_over,
    output logic                  winner
);

    localparam int TW = timer_width(SERVE_TICKS, GAMEOVER_TICKS);
    localparam logic [TW-1:0] SERVE_TERM = TW'(SERVE_TICKS - 1);
    localparam logic [TW-1:0] GO_TERM    = TW'(GAMEOVER_TICKS - 1);
    localparam logic [SCORE_BITS-1:0] WIN = SCORE_BITS'(WIN_SCORE);

    state_t                state, state_d;
    logic                  serve_dir, dir_d;
    logic [SCORE_BITS-1:0] sl_d, sr_d;
    logic                  win_d, launch_d, ldir_d;
    logic                  hold_d, over_d;
    logic                  timer_clr, timer_tick, timer_done;
    logic [TW-1:0]         timer_term;

    // The timer only runs in the two timed states.
    assign timer_tick = tick &&
        (state == ST_SERVE || state == ST_GAMEOVER);
    assign timer_term = (state == ST_SERVE) ? SERVE_TERM : GO_TERM;

    pong_tick_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .tick  (timer_tick),
        .term  (timer_term),
        .done  (timer_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, score updates and next output values.
    always_comb begin
        state_d  = state;
        sl_d     = score_left;
        sr_d     = score_right;
        dir_d    = serve_dir;
        win_d    = winner;
        launch_d = 1'b0;
        ldir_d   = launch_dir;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SERVE;
                    sl_d    = '0;
                    sr_d    = '0;
                    dir_d   = DIR_LEFT;
                end
            end
            ST_SERVE: begin
                if (timer_done) begin
                    state_d  = ST_PLAY;
                    launch_d = 1'b1;
                    ldir_d   = serve_dir;
                end
            end
            ST_PLAY: begin
                if (point_left && point_right) begin
                    // Simultaneous points replay the rally.
                    state_d = ST_SERVE;
                end else if (point_left) begin
                    sl_d = score_left + 1'b1;
                    if (sl_d == WIN) begin
                        state_d = ST_GAMEOVER;
                        win_d   = 1'b0;
                    end else begin
                        state_d = ST_SERVE;
                        dir_d   = DIR_LEFT;
                    end
                end else if (point_right) begin
                    sr_d = score_right + 1'b1;
                    if (sr_d == WIN) begin
                        state_d = ST_GAMEOVER;
                        win_d   = 1'b1;
                    end else begin
                        state_d = ST_SERVE;
                        dir_d   = DIR_RIGHT;
                    end
                end
            end
            ST_GAMEOVER: begin
                if (start) begin
                    state_d = ST_SERVE;
                    sl_d    = '0;
                    sr_d    = '0;
                end else if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        hold_d    = (state_d != ST_PLAY);
        over_d    = (state_d == ST_GAMEOVER);
        timer_clr = (state_d != state);
    end

    // Registered outputs, scores and serve direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_left  <= '0;
            score_right <= '0;
            serve_dir   <= 1'b0;
            winner      <= 1'b0;
            ball_hold   <= 1'b1;
            ball_launch <= 1'b0;
            launch_dir  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            score_left  <= sl_d;
            score_right <= sr_d;
            serve_dir   <= dir_d;
            winner      <= win_d;
            ball_hold   <= hold_d;
            ball_launch <= launch_d;
            launch_dir  <= ldir_d;
            game_over   <= over_d;
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl with a launch
// direction scoreboard.
module tb_pong_match_ctrl;

    localparam int SB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic          point_left = 1'b0;
    logic          point_right = 1'b0;
    logic          ball_hold, ball_launch, launch_dir;
    logic [SB-1:0] score_left, score_right;
    logic          game_over, winner;

    int   checks = 0;
    int   fails = 0;
    logic exp_q[$];
    int   rd = 0;

    // Monitor state, written only by the monitor process.
    logic obs_dir [0:63];
    int   launch_cnt = 0;
    int   dbl_cnt = 0;
    int   bad_hold = 0;
    logic prev_launch = 1'b0;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .WIN_SCORE      (3),
        .SCORE_BITS     (SB),
        .SERVE_TICKS    (3),
        .GAMEOVER_TICKS (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .start       (start),
        .point_left  (point_left),
        .point_right (point_right),
        .ball_hold   (ball_hold),
        .ball_launch (ball_launch),
        .launch_dir  (launch_dir),
        .score_left  (score_left),
        .score_right (score_right),
        .game_over   (game_over),
        .winner      (winner)
    );

    // Record every launch pulse seen on the falling edge.
    always @(negedge clk) begin
        if (ball_launch) begin
            if (launch_cnt < 64) obs_dir[launch_cnt] <= launch_dir;
            launch_cnt <= launch_cnt + 1;
            if (prev_launch) dbl_cnt <= dbl_cnt + 1;
            if (ball_hold) bad_hold <= bad_hold + 1;
        end
        prev_launch <= ball_launch;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(9);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_pts(input logic l, input logic r);
        point_left = l;
        point_right = r;
        step(1);
        point_left = 1'b0;
        point_right = 1'b0;
    endtask

    task automatic run_serve(input logic d);
        exp_q.push_back(d);
        repeat (3) pulse_tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++;
        if (ball_hold !== 1'b1) begin
            fails++;
            $display("FAIL reset_hold: got %b, expected 1", ball_hold);
        end
        checks++;
        if (ball_launch !== 1'b0) begin
            fails++;
            $display("FAIL reset_launch: got %b, expected 0", ball_launch);
        end
        checks++;
        if (launch_dir !== 1'b0) begin
            fails++;
            $display("FAIL reset_dir: got %b, expected 0", launch_dir);
        end
        checks++;
        if (score_left !== 4'd0 || score_right !== 4'd0) begin
            fails++;
            $display("FAIL reset_scores: got %0d/%0d, expected 0/0",
                     score_left, score_right);
        end
        checks++;
        if (game_over !== 1'b0 || winner !== 1'b0) begin
            fails++;
            $display("FAIL reset_over: got %b/%b, expected 0/0",
                     game_over, winner);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_serve();
        pulse_start();
        checks++;
        if (ball_hold !== 1'b1 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL serve_enter: hold/over %b/%b, expected 1/0",
                     ball_hold, game_over);
        end
        exp_q.push_back(1'b0);
        repeat (2) pulse_tick();
        checks++;
        if (ball_hold !== 1'b1 || launch_cnt != 0) begin
            fails++;
            $display("FAIL serve_early: hold %b launches %0d, expected 1/0",
                     ball_hold, launch_cnt);
        end
        pulse_tick();
        checks++;
        if (ball_hold !== 1'b0) begin
            fails++;
            $display("FAIL serve_play: hold %b, expected 0", ball_hold);
        end
        while (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            checks++;
            if (rd >= launch_cnt || obs_dir[rd] !== e) begin
                fails++;
                $display("FAIL serve_launch[%0d]: got cnt %0d dir %b, expected dir %b",
                         rd, launch_cnt, obs_dir[rd], e);
            end
            rd++;
        end
        checks++;
        if (launch_cnt != rd) begin
            fails++;
            $display("FAIL serve_count: got %0d launches, expected %0d",
                     launch_cnt, rd);
        end
    endtask

    task automatic test_point_right();
        pulse_pts(1'b0, 1'b1);
        checks++;
        if (score_right !== 4'd1 || score_left !== 4'd0 || ball_hold !== 1'b1) begin
            fails++;
            $display("FAIL point_right: got %0d/%0d hold %b, expected 0/1 hold 1",
                     score_left, score_right, ball_hold);
        end
        run_serve(1'b1);
        checks++;
        if (ball_hold !== 1'b0) begin
            fails++;
            $display("FAIL point_right_play: hold %b, expected 0", ball_hold);
        end
        while (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            checks++;
            if (rd >= launch_cnt || obs_dir[rd] !== e) begin
                fails++;
                $display("FAIL pr_launch[%0d]: got cnt %0d dir %b, expected dir %b",
                         rd, launch_cnt, obs_dir[rd], e);
            end
            rd++;
        end
        checks++;
        if (launch_cnt != rd) begin
            fails++;
            $display("FAIL pr_count: got %0d launches, expected %0d",
                     launch_cnt, rd);
        end
    endtask

    task automatic test_left_wins();
        pulse_pts(1'b1, 1'b0);
        checks++;
        if (score_left !== 4'd1 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL left_first: got %0d over %b, expected 1 over 0",
                     score_left, game_over);
        end
        run_serve(1'b0);
        pulse_pts(1'b1, 1'b0);
        run_serve(1'b0);
        pulse_pts(1'b1, 1'b0);
        checks++;
        if (score_left !== 4'd3 || game_over !== 1'b1 ||
            winner !== 1'b0 || ball_hold !== 1'b1) begin
            fails++;
            $display("FAIL left_win: score %0d over %b win %b hold %b, expected 3 1 0 1",
                     score_left, game_over, winner, ball_hold);
        end
        pulse_start();
        checks++;
        if (score_left !== 4'd0 || score_right !== 4'd0 ||
            game_over !== 1'b0 || ball_hold !== 1'b1) begin
            fails++;
            $display("FAIL restart: %0d/%0d over %b hold %b, expected 0/0 0 1",
                     score_left, score_right, game_over, ball_hold);
        end
        run_serve(1'b0);
        while (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            checks++;
            if (rd >= launch_cnt || obs_dir[rd] !== e) begin
                fails++;
                $display("FAIL lw_launch[%0d]: got cnt %0d dir %b, expected dir %b",
                         rd, launch_cnt, obs_dir[rd], e);
            end
            rd++;
        end
        checks++;
        if (launch_cnt != rd) begin
            fails++;
            $display("FAIL lw_count: got %0d launches, expected %0d",
                     launch_cnt, rd);
        end
    endtask

    task automatic test_replay();
        pulse_pts(1'b0, 1'b1);
        run_serve(1'b1);
        pulse_pts(1'b1, 1'b1);
        checks++;
        if (score_left !== 4'd0 || score_right !== 4'd1 ||
            ball_hold !== 1'b1 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL replay: %0d/%0d hold %b over %b, expected 0/1 1 0",
                     score_left, score_right, ball_hold, game_over);
        end
        run_serve(1'b1);
        while (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            checks++;
            if (rd >= launch_cnt || obs_dir[rd] !== e) begin
                fails++;
                $display("FAIL rp_launch[%0d]: got cnt %0d dir %b, expected dir %b",
                         rd, launch_cnt, obs_dir[rd], e);
            end
            rd++;
        end
        checks++;
        if (launch_cnt != rd) begin
            fails++;
            $display("FAIL rp_count: got %0d launches, expected %0d",
                     launch_cnt, rd);
        end
    endtask

    task automatic test_gameover();
        tick = 1'b1;
        pulse_pts(1'b0, 1'b1);
        tick = 1'b0;
        exp_q.push_back(1'b1);
        repeat (2) pulse_tick();
        checks++;
        if (score_right !== 4'd2 || ball_hold !== 1'b1) begin
            fails++;
            $display("FAIL tick_point: score %0d hold %b, expected 2 1",
                     score_right, ball_hold);
        end
        pulse_tick();
        pulse_pts(1'b0, 1'b1);
        checks++;
        if (game_over !== 1'b1 || winner !== 1'b1 || score_right !== 4'd3) begin
            fails++;
            $display("FAIL right_win: over %b win %b score %0d, expected 1 1 3",
                     game_over, winner, score_right);
        end
        pulse_tick();
        checks++;
        if (game_over !== 1'b1) begin
            fails++;
            $display("FAIL go_first_tick: over %b, expected 1", game_over);
        end
        pulse_tick();
        checks++;
        if (game_over !== 1'b0 || ball_hold !== 1'b1 || score_right !== 4'd3) begin
            fails++;
            $display("FAIL go_timeout: over %b hold %b score %0d, expected 0 1 3",
                     game_over, ball_hold, score_right);
        end
        pulse_pts(1'b1, 1'b0);
        checks++;
        if (score_left !== 4'd0 || score_right !== 4'd3) begin
            fails++;
            $display("FAIL idle_point: %0d/%0d, expected 0/3",
                     score_left, score_right);
        end
        pulse_start();
        run_serve(1'b0);
        repeat (2) begin
            pulse_pts(1'b1, 1'b0);
            run_serve(1'b0);
        end
        pulse_pts(1'b1, 1'b0);
        start = 1'b1;
        tick = 1'b1;
        step(1);
        start = 1'b0;
        tick = 1'b0;
        checks++;
        if (game_over !== 1'b0 || ball_hold !== 1'b1 ||
            score_left !== 4'd0 || score_right !== 4'd0) begin
            fails++;
            $display("FAIL start_tick: over %b hold %b %0d/%0d, expected 0 1 0/0",
                     game_over, ball_hold, score_left, score_right);
        end
        run_serve(1'b0);
        while (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            checks++;
            if (rd >= launch_cnt || obs_dir[rd] !== e) begin
                fails++;
                $display("FAIL go_launch[%0d]: got cnt %0d dir %b, expected dir %b",
                         rd, launch_cnt, obs_dir[rd], e);
            end
            rd++;
        end
        checks++;
        if (launch_cnt != rd) begin
            fails++;
            $display("FAIL go_count: got %0d launches, expected %0d",
                     launch_cnt, rd);
        end
    endtask

    task automatic test_reset_mid();
        pulse_pts(1'b0, 1'b1);
        pulse_pts(1'b1, 1'b0);
        checks++;
        if (score_left !== 4'd0 || score_right !== 4'd1) begin
            fails++;
            $display("FAIL serve_point: %0d/%0d, expected 0/1",
                     score_left, score_right);
        end
        repeat (2) pulse_tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ball_hold !== 1'b1 || ball_launch !== 1'b0 ||
            score_right !== 4'd0 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL rst_serve: hold %b launch %b score %0d over %b, expected 1 0 0 0",
                     ball_hold, ball_launch, score_right, game_over);
        end
        pulse_tick();
        rst_n = 1'b1;
        repeat (3) pulse_tick();
        checks++;
        if (ball_hold !== 1'b1) begin
            fails++;
            $display("FAIL idle_ticks: hold %b, expected 1", ball_hold);
        end
        pulse_start();
        run_serve(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ball_hold !== 1'b1 || ball_launch !== 1'b0 || launch_dir !== 1'b0) begin
            fails++;
            $display("FAIL rst_play: hold %b launch %b dir %b, expected 1 0 0",
                     ball_hold, ball_launch, launch_dir);
        end
        step(2);
        rst_n = 1'b1;
        step(3);
        while (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            checks++;
            if (rd >= launch_cnt || obs_dir[rd] !== e) begin
                fails++;
                $display("FAIL rm_launch[%0d]: got cnt %0d dir %b, expected dir %b",
                         rd, launch_cnt, obs_dir[rd], e);
            end
            rd++;
        end
        checks++;
        if (launch_cnt != rd) begin
            fails++;
            $display("FAIL rm_count: got %0d launches, expected %0d",
                     launch_cnt, rd);
        end
        checks++;
        if (dbl_cnt != 0 || bad_hold != 0) begin
            fails++;
            $display("FAIL launch_shape: long %0d held %0d, expected 0 0",
                     dbl_cnt, bad_hold);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_point_right();
        test_left_wins();
        test_replay();
        test_gameover();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
